// File: rtl/ucsbece154b_hazard_ctrl.sv
// ============================================================================
// Module   : ucsbece154b_hazard_ctrl
// Purpose  : Forwarding/stall/flush control with shadow E/M/W state and an
//            I/D-cache miss FSM. Optional macro HAZARD_PERF_CNT_EN adds
//            saturating performance counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ucsbece154b_hazard_ctrl #(
   parameter int REG_AW          = 5,
   parameter int LOAD_USE_STALLS = 1,
   parameter int CNT_W           = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] Rs1D_i,
   input  logic [REG_AW-1:0] Rs2D_i,
   input  logic [REG_AW-1:0] RdD_i,
   input  logic              RegWriteD_i,
   input  logic [1:0]        ResultSrcD_i,
   input  logic [REG_AW-1:0] Rs1E_i,
   input  logic [REG_AW-1:0] Rs2E_i,
   input  logic              MisspredictE_i,
   input  logic              IReady_i,
   input  logic              MemReqM_i,
   input  logic              DReady_i,
   output logic              StallF_o,
   output logic              StallD_o,
   output logic              StallE_o,
   output logic              StallM_o,
   output logic              FlushD_o,
   output logic              FlushE_o,
   output logic              FlushW_o,
   output logic [1:0]        ForwardAE_o,
   output logic [1:0]        ForwardBE_o,
   output logic [REG_AW-1:0] RdE_o,
   output logic [REG_AW-1:0] RdM_o,
   output logic [REG_AW-1:0] RdW_o,
   output logic              RegWriteW_o,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0]  ICycMiss_o,
   output logic [CNT_W-1:0]  DCycMiss_o,
   output logic [CNT_W-1:0]  LuStall_o,
   output logic [CNT_W-1:0]  Flush_o,
`endif
   output logic [1:0]        State_o
);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      IWAIT = 2'b01,
      DWAIT = 2'b10
   } state_t;

   localparam logic [REG_AW-1:0] c_zero = '0;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   state_t            state_q, state_d;
   logic [REG_AW-1:0] rd_e_q, rd_e_d, rd_m_q, rd_m_d, rd_w_q, rd_w_d;
   logic              rw_e_q, rw_e_d, rw_m_q, rw_m_d, rw_w_q, rw_w_d;
   logic              ld_e_q, ld_e_d, ld_m_q, ld_m_d;

   logic dmiss, lu, m_blocked;

   assign dmiss     = MemReqM_i & ~DReady_i;
   assign m_blocked = (LOAD_USE_STALLS == 2) & ld_m_q;
   assign lu = (ld_e_q & (rd_e_q != c_zero) & ((Rs1D_i == rd_e_q) | (Rs2D_i == rd_e_q)))
             | (m_blocked & (rd_m_q != c_zero) & ((Rs1D_i == rd_m_q) | (Rs2D_i == rd_m_q)));

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] s,
                                          input logic [REG_AW-1:0] rd_m, input logic rw_m,
                                          input logic blk_m,
                                          input logic [REG_AW-1:0] rd_w, input logic rw_w);
      if ((s == rd_m) && rw_m && (s != '0) && !blk_m) return 2'b10;
      else if ((s == rd_w) && rw_w && (s != '0))      return 2'b01;
      else                                            return 2'b00;
   endfunction

   always_comb begin
      StallF_o = 1'b0;
      StallD_o = 1'b0;
      StallE_o = 1'b0;
      StallM_o = 1'b0;
      FlushD_o = 1'b0;
      FlushE_o = 1'b0;
      FlushW_o = 1'b0;
      // E is frozen during a D-miss, so a pending redirect is simply held.
      if (dmiss) begin
         StallF_o = 1'b1;
         StallD_o = 1'b1;
         StallE_o = 1'b1;
         StallM_o = 1'b1;
         FlushW_o = 1'b1;
      end else if (MisspredictE_i) begin
         FlushD_o = 1'b1;
         FlushE_o = 1'b1;
      end else if (!IReady_i || lu) begin
         StallF_o = 1'b1;
         StallD_o = 1'b1;
         FlushE_o = 1'b1;
      end
      ForwardAE_o = fwd_sel(Rs1E_i, rd_m_q, rw_m_q, m_blocked, rd_w_q, rw_w_q);
      ForwardBE_o = fwd_sel(Rs2E_i, rd_m_q, rw_m_q, m_blocked, rd_w_q, rw_w_q);
   end

   always_comb begin
      state_d = state_q;
      if (dmiss) state_d = DWAIT;
      else begin
         case (state_q)
            RUN:     if (!IReady_i) state_d = IWAIT;
            IWAIT:   if (IReady_i)  state_d = RUN;
            DWAIT:   if (DReady_i)  state_d = RUN;
            default:                state_d = RUN;
         endcase
      end
   end

   always_comb begin
      rd_e_d = rd_e_q; rw_e_d = rw_e_q; ld_e_d = ld_e_q;
      rd_m_d = rd_m_q; rw_m_d = rw_m_q; ld_m_d = ld_m_q;
      rd_w_d = rd_w_q; rw_w_d = rw_w_q;
      if (FlushE_o) begin
         rd_e_d = '0; rw_e_d = 1'b0; ld_e_d = 1'b0;
      end else if (!StallE_o) begin
         rd_e_d = RdD_i; rw_e_d = RegWriteD_i; ld_e_d = (ResultSrcD_i == 2'b01);
      end
      if (!StallM_o) begin
         rd_m_d = rd_e_q; rw_m_d = rw_e_q; ld_m_d = ld_e_q;
      end
      if (FlushW_o) begin
         rd_w_d = '0; rw_w_d = 1'b0;
      end else if (!StallM_o) begin
         rd_w_d = rd_m_q; rw_w_d = rw_m_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         rd_e_q <= '0; rw_e_q <= 1'b0; ld_e_q <= 1'b0;
         rd_m_q <= '0; rw_m_q <= 1'b0; ld_m_q <= 1'b0;
         rd_w_q <= '0; rw_w_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_e_q <= rd_e_d; rw_e_q <= rw_e_d; ld_e_q <= ld_e_d;
         rd_m_q <= rd_m_d; rw_m_q <= rw_m_d; ld_m_q <= ld_m_d;
         rd_w_q <= rd_w_d; rw_w_q <= rw_w_d;
      end
   end

   assign RdE_o       = rd_e_q;
   assign RdM_o       = rd_m_q;
   assign RdW_o       = rd_w_q;
   assign RegWriteW_o = rw_w_q;
   assign State_o     = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] icyc_q, icyc_d, dcyc_q, dcyc_d, lu_q, lu_d, fl_q, fl_d;

   always_comb begin
      icyc_d = icyc_q;
      dcyc_d = dcyc_q;
      lu_d   = lu_q;
      fl_d   = fl_q;
      if (dmiss && (dcyc_q != '1)) dcyc_d = dcyc_q + 1'b1;
      if (!dmiss && MisspredictE_i && (fl_q != '1)) fl_d = fl_q + 1'b1;
      if (!dmiss && !MisspredictE_i && !IReady_i && (icyc_q != '1)) icyc_d = icyc_q + 1'b1;
      if (!dmiss && !MisspredictE_i && IReady_i && lu && (lu_q != '1)) lu_d = lu_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         icyc_q <= '0; dcyc_q <= '0; lu_q <= '0; fl_q <= '0;
      end else begin
         icyc_q <= icyc_d; dcyc_q <= dcyc_d; lu_q <= lu_d; fl_q <= fl_d;
      end
   end

   assign ICycMiss_o = icyc_q;
   assign DCycMiss_o = dcyc_q;
   assign LuStall_o  = lu_q;
   assign Flush_o    = fl_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ucsbece154b_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes expected outputs per cycle; a negedge
// monitor pops and compares against one of two DUTs (LOAD_USE_STALLS 1 / 2).
`default_nettype none

module tb_ucsbece154b_hazard_ctrl;

   localparam int MC = 1, MA = 2, MB = 4, MR = 8, MW = 16, MS = 32, ALL = 63;
   localparam logic [6:0] C0  = 7'b0000000;
   localparam logic [6:0] CLU = 7'b1100010;
   localparam logic [6:0] CMP = 7'b0000110;
   localparam logic [6:0] CDM = 7'b1111001;

   typedef struct {
      int         tag;
      bit         sel;
      logic [6:0] ctl;
      logic [1:0] fa, fb;
      logic [4:0] re, rm, rw;
      logic       rww;
      logic [1:0] st;
      int         m;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1d, rs2d, rdd, rs1e, rs2e;
   logic       rwd, mp, ir, mr, dr;
   logic [1:0] srcd;

   logic [6:0] ctl_a, ctl_b;
   logic [1:0] fa_a, fb_a, st_a, fa_b, fb_b, st_b;
   logic [4:0] re_a, rm_a, rw_a, re_b, rm_b, rw_b;
   logic       rww_a, rww_b;
   logic       sfa, sda, sea, sma, fda, fea, fwa;
   logic       sfb, sdb, seb, smb, fdb, feb, fwb;

   assign ctl_a = {sfa, sda, sea, sma, fda, fea, fwa};
   assign ctl_b = {sfb, sdb, seb, smb, fdb, feb, fwb};

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] pa0, pa1, pa2, pa3, pb0, pb1, pb2, pb3;
`endif

   always #5 clk = ~clk;

   ucsbece154b_hazard_ctrl #(.REG_AW(5), .LOAD_USE_STALLS(1), .CNT_W(32)) u_a (
      .clk(clk), .reset(rst_n),
      .Rs1D_i(rs1d), .Rs2D_i(rs2d), .RdD_i(rdd), .RegWriteD_i(rwd), .ResultSrcD_i(srcd),
      .Rs1E_i(rs1e), .Rs2E_i(rs2e), .MisspredictE_i(mp), .IReady_i(ir),
      .MemReqM_i(mr), .DReady_i(dr),
      .StallF_o(sfa), .StallD_o(sda), .StallE_o(sea), .StallM_o(sma),
      .FlushD_o(fda), .FlushE_o(fea), .FlushW_o(fwa),
      .ForwardAE_o(fa_a), .ForwardBE_o(fb_a),
      .RdE_o(re_a), .RdM_o(rm_a), .RdW_o(rw_a), .RegWriteW_o(rww_a),
`ifdef HAZARD_PERF_CNT_EN
      .ICycMiss_o(pa0), .DCycMiss_o(pa1), .LuStall_o(pa2), .Flush_o(pa3),
`endif
      .State_o(st_a)
   );

   ucsbece154b_hazard_ctrl #(.REG_AW(5), .LOAD_USE_STALLS(2), .CNT_W(32)) u_b (
      .clk(clk), .reset(rst_n),
      .Rs1D_i(rs1d), .Rs2D_i(rs2d), .RdD_i(rdd), .RegWriteD_i(rwd), .ResultSrcD_i(srcd),
      .Rs1E_i(rs1e), .Rs2E_i(rs2e), .MisspredictE_i(mp), .IReady_i(ir),
      .MemReqM_i(mr), .DReady_i(dr),
      .StallF_o(sfb), .StallD_o(sdb), .StallE_o(seb), .StallM_o(smb),
      .FlushD_o(fdb), .FlushE_o(feb), .FlushW_o(fwb),
      .ForwardAE_o(fa_b), .ForwardBE_o(fb_b),
      .RdE_o(re_b), .RdM_o(rm_b), .RdW_o(rw_b), .RegWriteW_o(rww_b),
`ifdef HAZARD_PERF_CNT_EN
      .ICycMiss_o(pb0), .DCycMiss_o(pb1), .LuStall_o(pb2), .Flush_o(pb3),
`endif
      .State_o(st_b)
   );

   task automatic chk(input int tag, input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL t%0d %s: got %0h expected %0h", tag, nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         if ((e.m & MC) != 0) chk(e.tag, "ctl", int'(e.sel ? ctl_b : ctl_a), int'(e.ctl));
         if ((e.m & MA) != 0) chk(e.tag, "fwdA", int'(e.sel ? fa_b : fa_a), int'(e.fa));
         if ((e.m & MB) != 0) chk(e.tag, "fwdB", int'(e.sel ? fb_b : fb_a), int'(e.fb));
         if ((e.m & MR) != 0) chk(e.tag, "rdEMW",
                                  int'(e.sel ? {re_b, rm_b, rw_b} : {re_a, rm_a, rw_a}),
                                  int'({e.re, e.rm, e.rw}));
         if ((e.m & MW) != 0) chk(e.tag, "regwW", int'(e.sel ? rww_b : rww_a), int'(e.rww));
         if ((e.m & MS) != 0) chk(e.tag, "state", int'(e.sel ? st_b : st_a), int'(e.st));
      end
   end

   task automatic ex(input int tag, input bit sel, input logic [6:0] ctl,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic [4:0] re, input logic [4:0] rm, input logic [4:0] rw,
                     input logic rww, input logic [1:0] st, input int m);
      exp_t e;
      e.tag = tag; e.sel = sel; e.ctl = ctl; e.fa = fa; e.fb = fb;
      e.re = re; e.rm = rm; e.rw = rw; e.rww = rww; e.st = st; e.m = m;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dd(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic rw, input logic ld);
      rs1d = r1; rs2d = r2; rdd = rd; rwd = rw; srcd = ld ? 2'b01 : 2'b00;
   endtask

   task automatic clr();
      dd(0, 0, 0, 0, 0);
      rs1e = 0; rs2e = 0; mp = 0; ir = 1; mr = 0; dr = 1;
   endtask

   task automatic rst_seq(input int tag);
      tick();
      rst_n = 0;
      clr();
      ex(tag, 0, C0, 0, 0, 0, 0, 0, 0, 0, ALL);
      ex(tag, 1, C0, 0, 0, 0, 0, 0, 0, 0, ALL);
      tick();
      rst_n = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      clr();
      rst_n = 0;
      repeat (2) @(posedge clk);

      // load-use, LOAD_USE_STALLS=1
      rst_seq(1);
      tick(); dd(0, 0, 5, 1, 1); ex(10, 0, C0, 0, 0, 0, 0, 0, 0, 0, MC | MR);
      tick(); dd(5, 0, 6, 1, 0); ex(11, 0, CLU, 0, 0, 5, 0, 0, 0, 0, MC | MR);
      tick(); rs1e = 5;          ex(12, 0, C0, 2'b10, 0, 0, 5, 0, 0, 0, MC | MA | MR);
      tick(); dd(0, 0, 0, 0, 0); ex(13, 0, C0, 2'b01, 0, 6, 0, 5, 1, 0, MC | MA | MR | MW);

      // load-use, LOAD_USE_STALLS=2
      rst_seq(2);
      tick(); dd(0, 0, 5, 1, 1); ex(20, 1, C0, 0, 0, 0, 0, 0, 0, 0, MC | MR);
      tick(); dd(5, 0, 6, 1, 0); ex(21, 1, CLU, 0, 0, 5, 0, 0, 0, 0, MC | MR);
      tick(); rs1e = 5;          ex(22, 1, CLU, 2'b00, 0, 0, 5, 0, 0, 0, MC | MA | MR);
      tick();                    ex(23, 1, C0, 2'b01, 0, 0, 0, 5, 1, 0, MC | MA | MR | MW);
      tick(); dd(0, 0, 0, 0, 0); ex(24, 1, C0, 2'b00, 0, 6, 0, 0, 0, 0, MC | MA | MR);

      // I-cache miss for three cycles
      rst_seq(3);
      tick(); dd(0, 0, 9, 1, 0); ex(30, 0, C0, 0, 0, 0, 0, 0, 0, 0, MC | MS);
      tick(); dd(0, 0, 0, 0, 0); ex(31, 0, C0, 0, 0, 9, 0, 0, 0, 0, MC | MR);
      tick(); ir = 0;            ex(32, 0, CLU, 0, 0, 0, 9, 0, 0, 2'b00, MC | MR | MW | MS);
      tick();                    ex(33, 0, CLU, 0, 0, 0, 0, 9, 1, 2'b01, MC | MR | MW | MS);
      tick();                    ex(34, 0, CLU, 0, 0, 0, 0, 0, 0, 2'b01, MC | MR | MW | MS);
      tick(); ir = 1;            ex(35, 0, C0, 0, 0, 0, 0, 0, 0, 2'b01, MC | MS);
      tick();                    ex(36, 0, C0, 0, 0, 0, 0, 0, 0, 2'b00, MC | MW | MS);

      // D-cache miss with a mispredict pending
      rst_seq(4);
      tick(); dd(0, 0, 3, 1, 0); ex(40, 0, C0, 0, 0, 0, 0, 0, 0, 0, MC);
      tick(); dd(0, 0, 0, 0, 0); ex(41, 0, C0, 0, 0, 3, 0, 0, 0, 0, MC | MR);
      tick(); dd(0, 0, 12, 1, 0); mr = 1; dr = 0; mp = 1;
      ex(42, 0, CDM, 0, 0, 0, 3, 0, 0, 2'b00, MC | MR | MW | MS);
      for (int i = 0; i < 3; i++) begin
         tick(); ex(43 + i, 0, CDM, 0, 0, 0, 3, 0, 0, 2'b10, MC | MR | MW | MS);
      end
      tick(); dr = 1;            ex(46, 0, CMP, 0, 0, 0, 3, 0, 0, 2'b10, MC | MR | MS);
      tick(); mr = 0; mp = 0; dd(0, 0, 0, 0, 0);
      ex(47, 0, C0, 0, 0, 0, 0, 3, 1, 2'b00, MC | MR | MW | MS);

      // forwarding: x0 never forwarded, M wins over W
      rst_seq(5);
      tick(); dd(0, 0, 0, 1, 0); ex(50, 0, C0, 0, 0, 0, 0, 0, 0, 0, MC);
      tick(); dd(0, 0, 7, 1, 0);
      tick(); ex(52, 0, C0, 2'b00, 2'b00, 7, 0, 0, 0, 0, MA | MB | MR);
      tick(); dd(0, 0, 0, 0, 0); ex(53, 0, C0, 2'b00, 0, 7, 7, 0, 0, 0, MA | MR);
      tick(); rs1e = 7; rs2e = 7; ex(54, 0, C0, 2'b10, 2'b10, 0, 7, 7, 1, 0, MA | MB | MR | MW);
      tick(); rs2e = 0;          ex(55, 0, C0, 2'b01, 2'b00, 0, 0, 7, 1, 0, MA | MB | MR | MW);

      // asynchronous reset while in DWAIT
      rst_seq(6);
      tick(); dd(0, 0, 4, 1, 0);
      tick(); dd(0, 0, 8, 1, 0);
      tick(); dd(0, 0, 0, 0, 0); mr = 1; dr = 0;
      ex(62, 0, CDM, 0, 0, 8, 4, 0, 0, 2'b00, MC | MR | MS);
      tick(); ex(63, 0, CDM, 0, 0, 8, 4, 0, 0, 2'b10, MC | MR | MS);
      tick(); rst_n = 0;
      ex(64, 0, CDM, 0, 0, 0, 0, 0, 0, 2'b00, MC | MR | MW | MS);
      tick(); rst_n = 1; clr();

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries never compared", q.size());
      end
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
